// File: rtl/fdt_scheduler_pkg.sv
// rtl/fdt_scheduler_pkg.sv - ISO/IEC 14443-2 frame delay time constants and scheduler state type
//
// Purpose: shared constants for the PICC rx->tx turnaround scheduler.
// Ports:   none (package).
package fdt_scheduler_pkg;

    // FDT slots sit on a 128-carrier-cycle grid, offset by the polarity of the last PCD bit.
    localparam int FDT_GRID          = 128;
    localparam int FDT_OFFSET_LAST1  = 84;
    localparam int FDT_OFFSET_LAST0  = 20;
    localparam int FDT_N_MIN_DEFAULT = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX      = 3'd1,
        DISCARD = 3'd2,
        WAIT    = 3'd3,
        TX      = 3'd4
    } fdt_state_t;

endpackage

// File: rtl/fdt_scheduler.sv
// rtl/fdt_scheduler.sv - PICC frame delay time scheduler releasing the tx encoder on the FDT grid
//
// Purpose: times the rx->tx turnaround from the end of a PCD frame and fires tx_go_o only
//          on a legal slot n*128+84 (last bit 1) or n*128+20 (last bit 0), compensated for
//          rx and tx pipeline latency. Gates the rx path while the PICC transmits.
// Ports:
//   clk_i          carrier clock (13.56 MHz)
//   rst_ni         asynchronous active-low reset
//   rx_soc_i       start of PCD frame, 1-cycle pulse
//   rx_eoc_i       end of PCD frame, level until next soc
//   rx_error_i     PCD frame decode error, 1-cycle pulse
//   last_bit_i     value of last PCD bit, stable from eoc to next soc
//   cfg_strict_i   1: only the first slot (N_MIN) may be used
//   tx_req_i       reply ready, level held until tx_go_o
//   tx_done_i      tx encoder finished, 1-cycle pulse
//   tx_go_o        start tx encoder, 1-cycle pulse
//   tx_missed_o    reply dropped (strict miss or last slot passed), 1-cycle pulse
//   rx_enable_o    rx path live; low while transmitting
//   busy_o         scheduler not idle
module fdt_scheduler
    import fdt_scheduler_pkg::*;
#(
    parameter int N_MIN      = FDT_N_MIN_DEFAULT,
    parameter int N_MAX      = 64,
    parameter int RX_LATENCY = 3,
    parameter int TX_LATENCY = 2,
    parameter int CNT_W      = 14
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_soc_i,
    input  logic rx_eoc_i,
    input  logic rx_error_i,
    input  logic last_bit_i,
    input  logic cfg_strict_i,
    input  logic tx_req_i,
    input  logic tx_done_i,
    output logic tx_go_o,
    output logic tx_missed_o,
    output logic rx_enable_o,
    output logic busy_o
);

    localparam int K_W = $clog2(N_MAX + 1);
    localparam int TOTAL_LAT = RX_LATENCY + TX_LATENCY;

    localparam logic [CNT_W-1:0] T_FIRST_L1  = CNT_W'(N_MIN * FDT_GRID + FDT_OFFSET_LAST1 - TOTAL_LAT);
    localparam logic [CNT_W-1:0] T_FIRST_L0  = CNT_W'(N_MIN * FDT_GRID + FDT_OFFSET_LAST0 - TOTAL_LAT);
    localparam logic [CNT_W-1:0] GRID        = CNT_W'(FDT_GRID);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [K_W-1:0]   SLOTS_EXTRA = K_W'(N_MAX - N_MIN);

    fdt_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [K_W-1:0]   slots_left_q, slots_left_d;
    logic             late_q, late_d;
    logic             tx_go_q, tx_go_d;
    logic             tx_missed_q, tx_missed_d;
    logic             rx_enable_q, rx_enable_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             slot_hit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        slots_left_d = slots_left_q;
        late_d       = late_q;
        tx_go_d      = 1'b0;
        tx_missed_d  = 1'b0;

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Compare against the count of the coming cycle so the registered tx_go lands
        // exactly in the slot cycle rather than one cycle late.
        slot_hit = (cnt_inc == target_q);

        unique case (state_q)
            IDLE: begin
                if (rx_soc_i) state_d = RX;
            end
            RX: begin
                if (rx_error_i) begin
                    state_d = DISCARD;
                end else if (rx_eoc_i) begin
                    // last_bit and cfg_strict are consumed only here; their effect lives
                    // on in the first target and the remaining-slot budget.
                    state_d      = WAIT;
                    cnt_d        = '0;
                    target_d     = last_bit_i ? T_FIRST_L1 : T_FIRST_L0;
                    slots_left_d = cfg_strict_i ? '0 : SLOTS_EXTRA;
                    late_d       = 1'b0;
                end
            end
            DISCARD: begin
                if (rx_eoc_i) state_d = IDLE;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (rx_soc_i) begin
                    state_d = RX;
                end else if (slot_hit) begin
                    if (late_q) begin
                        tx_missed_d = 1'b1;
                        state_d     = IDLE;
                    end else if (tx_req_i) begin
                        tx_go_d = 1'b1;
                        state_d = TX;
                    end else if (slots_left_q == '0) begin
                        // Last permitted slot passed unused: arm the miss one cycle later.
                        target_d = target_q + 1'b1;
                        late_d   = 1'b1;
                    end else begin
                        target_d     = target_q + GRID;
                        slots_left_d = slots_left_q - 1'b1;
                    end
                end
            end
            TX: begin
                if (tx_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // rx goes dark the cycle after tx_go and returns the cycle after tx_done.
        rx_enable_d = !(state_q == TX && !tx_done_i);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            target_q     <= '0;
            slots_left_q <= '0;
            late_q       <= 1'b0;
            tx_go_q      <= 1'b0;
            tx_missed_q  <= 1'b0;
            rx_enable_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            slots_left_q <= slots_left_d;
            late_q       <= late_d;
            tx_go_q      <= tx_go_d;
            tx_missed_q  <= tx_missed_d;
            rx_enable_q  <= rx_enable_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_go_o     = tx_go_q;
    assign tx_missed_o = tx_missed_q;
    assign rx_enable_o = rx_enable_q;
    assign busy_o      = busy_q;

endmodule
